// File: rtl/sample_pkg.sv
// Shared types, defaults and size helpers for the sample assembler.
package sample_pkg;

  localparam int DEF_MAX_BYTES     = 4;
  localparam int DEF_DEFAULT_BYTES = 2;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } asm_state_t;

  function automatic logic size_illegal(input logic [2:0] size, input int max_bytes);
    return (size == 3'd0) || (int'(size) > max_bytes);
  endfunction

  // Bytes per sample actually used: an illegal request falls back to the default size.
  function automatic logic [2:0] legal_bytes(input logic [2:0] size, input int max_bytes,
                                             input int dflt);
    logic [2:0] n;
    if (size_illegal(size, max_bytes)) begin
      n = 3'(dflt);
    end else begin
      n = size;
    end
    return n;
  endfunction

endpackage

// File: rtl/sample_assembler_if.sv
// Byte-in / sample-out bundle of the sample assembler; slave is the assembler side.
interface sample_assembler_if #(
  parameter int MAX_BYTES = 4,
  parameter int NUM_CH    = 2
);
  localparam int OUT_W = 8 * MAX_BYTES;
  localparam int CH_W  = $clog2(NUM_CH);

  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             byte_ready;
  logic [2:0]       sample_size;
  logic [OUT_W-1:0] sample_data;
  logic [CH_W-1:0]  sample_ch;
  logic             sample_last;
  logic             sample_valid;
  logic             sample_ready;
  logic             size_err;

  modport master (
    output byte_data, byte_valid, sample_size, sample_ready,
    input  byte_ready, sample_data, sample_ch, sample_last, sample_valid, size_err
  );

  modport slave (
    input  byte_data, byte_valid, sample_size, sample_ready,
    output byte_ready, sample_data, sample_ch, sample_last, sample_valid, size_err
  );
endinterface

// File: rtl/sample_pack_reg.sv
// Word register with byte-lane writes, frame-start zero fill and an optional whole-word load.
module sample_pack_reg #(
  parameter int MAX_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   start,
  input  logic [2:0]             lane,
  input  logic [7:0]             data,
  input  logic                   load,
  input  logic [8*MAX_BYTES-1:0] load_word,
  output logic [8*MAX_BYTES-1:0] word
);

  logic [MAX_BYTES-1:0][7:0] lanes_r;

  // Per-lane update: the written byte wins, then start-of-sample clear, then bulk load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_BYTES; i++) begin
        lanes_r[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < MAX_BYTES; i++) begin
        if (wr_en && (lane == 3'(i))) begin
          lanes_r[i] <= data;
        end else if (wr_en && start) begin
          lanes_r[i] <= 8'h00;
        end else if (load) begin
          lanes_r[i] <= load_word[8*i +: 8];
        end else begin
          lanes_r[i] <= lanes_r[i];
        end
      end
    end
  end

  assign word = lanes_r;

endmodule

// File: rtl/sample_assembler.sv
// Packs little-endian byte streams into MSB-aligned PCM words tagged with channel and frame end.
// Build macro SAMPLE_SKID_EN adds a shadow word so bytes keep flowing while a sample waits.
module sample_assembler
  import sample_pkg::*;
#(
  parameter int MAX_BYTES     = DEF_MAX_BYTES,
  parameter int NUM_CH        = 2,
  parameter int DEFAULT_BYTES = DEF_DEFAULT_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  sample_assembler_if.slave bus
);

  localparam int OUT_W = 8 * MAX_BYTES;
  localparam int CH_W  = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] CH_ZERO = CH_W'(32'd0);
  localparam logic [CH_W-1:0] CH_ONE  = CH_W'(32'd1);

  asm_state_t       state_r;
  logic             byte_ready_r;
  logic             sample_valid_r;
  logic             sample_last_r;
  logic             size_err_r;
  logic [2:0]       byte_cnt_r;
  logic [2:0]       size_r;
  logic [CH_W-1:0]  asm_ch_r;
  logic [CH_W-1:0]  sample_ch_r;

  logic             byte_acc_s;
  logic             smp_acc_s;
  logic             frame_start_s;
  logic             first_byte_s;
  logic             last_byte_s;
  logic [2:0]       eff_n_s;
  logic [2:0]       lane_s;
  logic [CH_W-1:0]  asm_ch_nxt_s;
  logic [CH_W-1:0]  sample_ch_nxt_s;
  logic [OUT_W-1:0] out_word_s;

  assign byte_acc_s    = bus.byte_valid && byte_ready_r;
  assign smp_acc_s     = sample_valid_r && bus.sample_ready;
  assign first_byte_s  = (byte_cnt_r == 3'd0);
  assign frame_start_s = first_byte_s && (asm_ch_r == CH_ZERO);

  // Size in force for the current byte: sampled live at frame start, latched otherwise.
  always_comb begin
    if (frame_start_s) begin
      eff_n_s = legal_bytes(bus.sample_size, MAX_BYTES, DEFAULT_BYTES);
    end else begin
      eff_n_s = size_r;
    end
  end

  assign last_byte_s = byte_acc_s && (byte_cnt_r == (eff_n_s - 3'd1));
  // Byte k of an N-byte sample sits N-1-k lanes below the top lane.
  assign lane_s      = 3'(MAX_BYTES) - eff_n_s + byte_cnt_r;

  // Channel successors for the assembling and the presented sample.
  always_comb begin
    if (asm_ch_r == LAST_CH) begin
      asm_ch_nxt_s = CH_ZERO;
    end else begin
      asm_ch_nxt_s = asm_ch_r + CH_ONE;
    end
    if (sample_ch_r == LAST_CH) begin
      sample_ch_nxt_s = CH_ZERO;
    end else begin
      sample_ch_nxt_s = sample_ch_r + CH_ONE;
    end
  end

`ifdef SAMPLE_SKID_EN
  logic             shd_full_r;
  logic             out_wr_s;
  logic             shd_wr_s;
  logic [OUT_W-1:0] shd_word_s;

  // While the output is occupied bytes go to the shadow; a freed output absorbs the shadow.
  assign out_wr_s = byte_acc_s && ((state_r == COLLECT) || smp_acc_s);
  assign shd_wr_s = byte_acc_s && (state_r == HOLD) && !smp_acc_s;

  sample_pack_reg #(.MAX_BYTES(MAX_BYTES)) u_out (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (out_wr_s),
    .start     (first_byte_s),
    .lane      (lane_s),
    .data      (bus.byte_data),
    .load      (smp_acc_s),
    .load_word (shd_word_s),
    .word      (out_word_s)
  );

  sample_pack_reg #(.MAX_BYTES(MAX_BYTES)) u_shd (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (shd_wr_s),
    .start     (first_byte_s),
    .lane      (lane_s),
    .data      (bus.byte_data),
    .load      (1'b0),
    .load_word ({OUT_W{1'b0}}),
    .word      (shd_word_s)
  );
`else
  sample_pack_reg #(.MAX_BYTES(MAX_BYTES)) u_out (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (byte_acc_s),
    .start     (first_byte_s),
    .lane      (lane_s),
    .data      (bus.byte_data),
    .load      (1'b0),
    .load_word ({OUT_W{1'b0}}),
    .word      (out_word_s)
  );
`endif

  // Control FSM: counters, size latch, handshake flags and sample tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= COLLECT;
      byte_ready_r   <= 1'b0;
      sample_valid_r <= 1'b0;
      sample_last_r  <= 1'b0;
      size_err_r     <= 1'b0;
      byte_cnt_r     <= 3'd0;
      size_r         <= 3'(DEFAULT_BYTES);
      asm_ch_r       <= CH_ZERO;
      sample_ch_r    <= CH_ZERO;
`ifdef SAMPLE_SKID_EN
      shd_full_r     <= 1'b0;
`endif
    end else begin
      if (byte_acc_s && frame_start_s) begin
        size_r <= eff_n_s;
        if (size_illegal(bus.sample_size, MAX_BYTES)) begin
          size_err_r <= 1'b1;
        end
      end

      if (byte_acc_s) begin
        if (last_byte_s) begin
          byte_cnt_r <= 3'd0;
          asm_ch_r   <= asm_ch_nxt_s;
        end else begin
          byte_cnt_r <= byte_cnt_r + 3'd1;
        end
      end

      if (smp_acc_s) begin
        sample_ch_r   <= sample_ch_nxt_s;
        sample_last_r <= (sample_ch_nxt_s == LAST_CH);
      end

      case (state_r)
        COLLECT: begin
          byte_ready_r <= 1'b1;
          if (last_byte_s) begin
            state_r        <= HOLD;
            sample_valid_r <= 1'b1;
`ifndef SAMPLE_SKID_EN
            byte_ready_r   <= 1'b0;
`endif
          end
        end
        HOLD: begin
`ifdef SAMPLE_SKID_EN
          if (smp_acc_s && shd_full_r) begin
            shd_full_r   <= 1'b0;
            byte_ready_r <= 1'b1;
          end else if (smp_acc_s && !last_byte_s) begin
            state_r        <= COLLECT;
            sample_valid_r <= 1'b0;
          end else if (!smp_acc_s && last_byte_s) begin
            shd_full_r   <= 1'b1;
            byte_ready_r <= 1'b0;
          end
`else
          if (smp_acc_s) begin
            state_r        <= COLLECT;
            sample_valid_r <= 1'b0;
            byte_ready_r   <= 1'b1;
          end
`endif
        end
        default: begin
          state_r        <= COLLECT;
          sample_valid_r <= 1'b0;
          byte_ready_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready   = byte_ready_r;
  assign bus.sample_valid = sample_valid_r;
  assign bus.sample_data  = out_word_s;
  assign bus.sample_ch    = sample_ch_r;
  assign bus.sample_last  = sample_last_r;
  assign bus.size_err     = size_err_r;

endmodule

// File: tb/tb_sample_assembler.sv
// Directed + randomized bench for sample_assembler against a queue-based packing model.
module tb_sample_assembler;

  localparam int NUM_CH = 2;
`ifdef SAMPLE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  sample_assembler_if #(.MAX_BYTES(4), .NUM_CH(NUM_CH)) bus ();

  sample_assembler #(.MAX_BYTES(4), .NUM_CH(NUM_CH), .DEFAULT_BYTES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  int           m_ch;
  int           m_n;
  bit           m_err;
  logic [7:0]   m_bytes[$];
  logic [31:0]  exp_data[$];
  int           exp_ch[$];
  int           exp_last[$];
  // log of samples taken by the downstream side
  logic [31:0]  log_data[$];
  int           log_ch[$];
  int           log_last[$];
  int           log_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ch = 0; m_n = 2; m_err = 1'b0;
    m_bytes.delete(); exp_data.delete(); exp_ch.delete(); exp_last.delete();
  endtask

  task automatic log_clear();
    log_data.delete(); log_ch.delete(); log_last.delete(); log_cyc.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input logic [2:0] sz);
    logic [31:0] w;
    int msb;
    if (m_bytes.size() == 0 && m_ch == 0) begin
      if (sz == 3'd0 || sz > 3'd4) begin
        m_n = 2; m_err = 1'b1;
      end else begin
        m_n = int'(sz);
      end
    end
    m_bytes.push_back(b);
    if (m_bytes.size() == m_n) begin
      w = 32'h0;
      for (int k = 0; k < m_n; k++) begin
        msb = 31 - 8 * (m_n - 1 - k);
        w[msb -: 8] = m_bytes[k];
      end
      exp_data.push_back(w);
      exp_ch.push_back(m_ch);
      exp_last.push_back((m_ch == NUM_CH - 1) ? 1 : 0);
      m_bytes.delete();
      m_ch = (m_ch + 1) % NUM_CH;
    end
  endtask

  // One clock: check outputs, drive inputs, track handshakes, advance to edge+1.
  task automatic do_cycle(input bit bv, input logic [7:0] bd, input bit sr,
                          input logic [2:0] sz, output bit byte_acc);
    bit smp_acc;
    if (bus.sample_valid === 1'b1) begin
      check("valid_has_expected", 32'(exp_data.size() != 0), 32'd1);
      if (exp_data.size() != 0) begin
        check("sample_data", bus.sample_data, exp_data[0]);
        check("sample_ch", 32'(bus.sample_ch), 32'(exp_ch[0]));
        check("sample_last", 32'(bus.sample_last), 32'(exp_last[0]));
      end
    end
    check("size_err", 32'(bus.size_err), 32'(m_err));
`ifndef SAMPLE_SKID_EN
    check("byte_ready_vs_hold", 32'(bus.byte_ready), 32'(!bus.sample_valid));
`endif
    bus.byte_valid   = bv;
    bus.byte_data    = bd;
    bus.sample_ready = sr;
    bus.sample_size  = sz;
    byte_acc = bv && (bus.byte_ready === 1'b1);
    smp_acc  = sr && (bus.sample_valid === 1'b1);
    if (smp_acc) begin
      log_data.push_back(bus.sample_data);
      log_ch.push_back(int'(bus.sample_ch));
      log_last.push_back(int'(bus.sample_last));
      log_cyc.push_back(cyc);
      if (exp_data.size() != 0) begin
        void'(exp_data.pop_front()); void'(exp_ch.pop_front()); void'(exp_last.pop_front());
      end
    end
    if (byte_acc) model_byte(bd, sz);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.byte_valid = 1'b0; bus.byte_data = 8'h00; bus.sample_ready = 1'b0; bus.sample_size = 3'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_valid", 32'(bus.sample_valid), 32'd0);
    check("rst_data", bus.sample_data, 32'h0);
    check("rst_ch", 32'(bus.sample_ch), 32'd0);
    check("rst_last", 32'(bus.sample_last), 32'd0);
    check("rst_size_err", 32'(bus.size_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_byte_ready", 32'(bus.byte_ready), 32'd1);
    model_reset();
  endtask

  task automatic feed(input byte_q_t bytes, input logic [2:0] sz, input int gap_pct,
                      input int stall_pct);
    int idx = 0;
    int guard = 0;
    bit bv, sr, acc;
    while ((idx < bytes.size() || exp_data.size() != 0) && guard < 600) begin
      bv = (idx < bytes.size()) && (int'($urandom_range(99)) >= gap_pct);
      sr = int'($urandom_range(99)) >= stall_pct;
      do_cycle(bv, bv ? bytes[idx] : 8'h00, sr, sz, acc);
      if (acc) idx++;
      guard++;
    end
    check("feed_within_budget", 32'(guard < 600), 32'd1);
  endtask

  initial begin
    byte_q_t q;
    bit acc;
    logic [2:0] sz;
    int n;
    model_reset();

    // 2-byte samples, free-flowing output
    do_reset(); log_clear();
    q = {8'h34, 8'h12, 8'h78, 8'h56};
    feed(q, 3'd2, 0, 0);
    check("t1_count", 32'(log_data.size()), 32'd2);
    check("t1_data0", log_data[0], 32'h12340000);
    check("t1_ch0", 32'(log_ch[0]), 32'd0);
    check("t1_last0", 32'(log_last[0]), 32'd0);
    check("t1_data1", log_data[1], 32'h56780000);
    check("t1_ch1", 32'(log_ch[1]), 32'd1);
    check("t1_last1", 32'(log_last[1]), 32'd1);

    // 3-byte sample held under backpressure
    do_reset(); log_clear();
    q = {8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, q[i], 1'b0, 3'd3, acc);
      check("t2_byte_acc", 32'(acc), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 32'(bus.sample_valid), 32'd1);
      check("t2_hold_data", bus.sample_data, 32'hCCBBAA00);
      check("t2_hold_byte_ready", 32'(bus.byte_ready), SKID ? 32'd1 : 32'd0);
      do_cycle(1'b0, 8'h00, 1'b0, 3'd3, acc);
    end
    do_cycle(1'b0, 8'h00, 1'b1, 3'd3, acc);
    check("t2_taken", 32'(log_data.size()), 32'd1);
    check("t2_valid_drops", 32'(bus.sample_valid), 32'd0);

    // illegal size at frame start, mid-frame size change ignored
    do_reset(); log_clear();
    q = {8'h11, 8'h22};
    feed(q, 3'd0, 20, 20);
    q = {8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    feed(q, 3'd4, 20, 20);
    check("t3_count", 32'(log_data.size()), 32'd4);
    check("t3_data0", log_data[0], 32'h22110000);
    check("t3_data1", log_data[1], 32'h44330000);
    check("t3_data2", log_data[2], 32'h88776655);
    check("t3_data3", log_data[3], 32'hCCBBAA99);
    check("t3_size_err_sticky", 32'(bus.size_err), 32'd1);

    // reset discards a partial sample
    do_reset(); log_clear();
    q = {8'hEE};
    feed(q, 3'd4, 0, 0);
    do_reset(); log_clear();
    q = {8'h01, 8'h02, 8'h03, 8'h04};
    feed(q, 3'd4, 0, 0);
    check("t4_count", 32'(log_data.size()), 32'd1);
    check("t4_data", log_data[0], 32'h04030201);
    check("t4_ch", 32'(log_ch[0]), 32'd0);

    // 1-byte samples with gaps and stalls
    do_reset(); log_clear();
    q = {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    feed(q, 3'd1, 40, 30);
    check("t5_count", 32'(log_data.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("t5_ch_seq", 32'(log_ch[i]), 32'(i % 2));
      check("t5_last_seq", 32'(log_last[i]), 32'(i % 2));
      check("t5_data", log_data[i], {q[i], 24'h000000});
    end

    // throughput with continuous bytes and ready
    do_reset(); log_clear();
    q = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    feed(q, 3'd2, 0, 0);
    check("t6_count", 32'(log_cyc.size()), 32'd4);
    for (int i = 0; i < 3; i++) begin
      check("t6_spacing", 32'(log_cyc[i+1] - log_cyc[i]), SKID ? 32'd2 : 32'd3);
    end

    // randomized frames, sizes including illegal ones
    do_reset(); log_clear();
    for (int f = 0; f < 8; f++) begin
      sz = 3'($urandom_range(7));
      n  = (sz == 3'd0 || sz > 3'd4) ? 2 : int'(sz);
      q.delete();
      for (int i = 0; i < NUM_CH * n; i++) q.push_back(8'($urandom_range(255)));
      feed(q, sz, 30, 30);
    end
    check("rand_all_taken", 32'(exp_data.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
